// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit (AND/OR/XOR/NOR) among NREQ
// requesters; the tagged result lands in a single registered stage with valid/ready.
module logic_unit_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_opA,
  input  logic [NREQ*WIDTH-1:0] req_opB,
  input  logic [NREQ*2-1:0]     req_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_result
);

  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   gidx;
  logic [IDW-1:0]   next_ptr;
  logic [NREQ-1:0]  grant;
  logic             found;
  logic             can_issue;
  logic             accept;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] fresult;

  assign can_issue = ~rsp_valid | rsp_ready;

  // Two ascending passes: indices at/above rr_ptr first, then the wrapped-around low ones.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i] && (i >= int'(rr_ptr))) begin
        grant[i] = 1'b1;
        gidx     = IDW'(i);
        found    = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i] && (i < int'(rr_ptr))) begin
        grant[i] = 1'b1;
        gidx     = IDW'(i);
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a  = req_opA[i*WIDTH +: WIDTH];
        sel_b  = req_opB[i*WIDTH +: WIDTH];
        sel_op = req_op[i*2 +: 2];
      end
    end
  end

  always_comb begin
    fresult = '0;
    case (sel_op)
      2'b00:   fresult = sel_a & sel_b;
      2'b01:   fresult = sel_a | sel_b;
      2'b10:   fresult = sel_a ^ sel_b;
      default: fresult = ~(sel_a | sel_b);
    endcase
  end

  assign req_ready = grant & {NREQ{can_issue & ~reset}};
  assign accept    = |(req_valid & req_ready);
  // Explicit wrap keeps the pointer below NREQ when NREQ is not a power of two.
  assign next_ptr  = (gidx == IDW'(NREQ-1)) ? '0 : gidx + IDW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rr_ptr     <= '0;
    end else if (accept) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= gidx;
      rsp_result <= fresult;
      rr_ptr     <= next_ptr;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: hand-computed results, grants and
// handshake behaviour checked with immediate assertions.
module tb_logic_unit_arbiter;

  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_opA;
  logic [NREQ*WIDTH-1:0] req_opB;
  logic [NREQ*2-1:0]     req_op;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_result;

  int total  = 0;
  int passed = 0;

  logic [31:0] full_res [4];
  logic [3:0]  full_rdy;

  logic_unit_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_opA   (req_opA),
    .req_opB   (req_opB),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_result(rsp_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h required %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    req_valid[i]         = v;
    req_op[i*2 +: 2]     = op;
    req_opA[i*32 +: 32]  = a;
    req_opB[i*32 +: 32]  = b;
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic [1:0] id,
                         input logic [31:0] res);
    chk({tag, "_valid"}, {31'd0, rsp_valid}, {31'd0, v});
    chk({tag, "_id"}, {30'd0, rsp_id}, {30'd0, id});
    chk({tag, "_result"}, rsp_result, res);
  endtask

  task automatic chk_rdy(input string tag, input logic [3:0] exp);
    #1;
    chk({tag, "_ready"}, {28'd0, req_ready}, {28'd0, exp});
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_opA   = '0;
    req_opB   = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    chk_rsp("reset", 1'b0, 2'd0, 32'h0);
    chk_rdy("reset", 4'b0000);
    reset = 1'b0;

    // single requester 1, all four functions back-to-back
    set_req(1, 1'b1, 2'b00, 32'hF0F0F0F0, 32'hFF00FF00);
    chk_rdy("single_and", 4'b0010);
    tick();
    chk_rsp("single_and", 1'b1, 2'd1, 32'hF000F000);
    set_req(1, 1'b1, 2'b01, 32'hF0F0F0F0, 32'hFF00FF00);
    chk_rdy("single_or", 4'b0010);
    tick();
    chk_rsp("single_or", 1'b1, 2'd1, 32'hFFF0FFF0);
    set_req(1, 1'b1, 2'b10, 32'hF0F0F0F0, 32'hFF00FF00);
    tick();
    chk_rsp("single_xor", 1'b1, 2'd1, 32'h0FF00FF0);
    set_req(1, 1'b1, 2'b11, 32'hF0F0F0F0, 32'hFF00FF00);
    tick();
    chk_rsp("single_nor", 1'b1, 2'd1, 32'h000F000F);
    set_req(1, 1'b0, 2'b00, 32'h0, 32'h0);
    tick();
    chk_rsp("drain_empty", 1'b0, 2'd1, 32'h000F000F);

    // NOR edges (rr_ptr = 2)
    set_req(1, 1'b1, 2'b11, 32'h0, 32'h0);
    tick();
    chk_rsp("nor_zero", 1'b1, 2'd1, 32'hFFFFFFFF);
    set_req(1, 1'b1, 2'b11, 32'hFFFFFFFF, 32'h0);
    tick();
    chk_rsp("nor_ones", 1'b1, 2'd1, 32'h0);
    set_req(1, 1'b0, 2'b00, 32'h0, 32'h0);

    // pointer skip: accept req0 to set rr_ptr = 1, then offer 0 and 3
    set_req(0, 1'b1, 2'b00, 32'h00001234, 32'h00001234);
    tick();
    chk_rsp("ptr_setup", 1'b1, 2'd0, 32'h00001234);
    set_req(0, 1'b1, 2'b10, 32'hAAAA0000, 32'h0000AAAA);
    set_req(3, 1'b1, 2'b01, 32'h00000001, 32'h00000002);
    chk_rdy("skip_first", 4'b1000);
    tick();
    chk_rsp("skip_first", 1'b1, 2'd3, 32'h00000003);
    set_req(3, 1'b0, 2'b00, 32'h0, 32'h0);
    chk_rdy("skip_second", 4'b0001);
    tick();
    chk_rsp("skip_second", 1'b1, 2'd0, 32'hAAAAAAAA);
    set_req(0, 1'b0, 2'b00, 32'h0, 32'h0);
    tick();
    chk_rsp("skip_drain", 1'b0, 2'd0, 32'hAAAAAAAA);

    // back-pressure with req2 (rr_ptr = 1), req3 pending during the stall
    rsp_ready = 1'b0;
    set_req(2, 1'b1, 2'b00, 32'hFFFF0000, 32'h0F0F0F0F);
    chk_rdy("bp_accept", 4'b0100);
    tick();
    chk_rsp("bp_accept", 1'b1, 2'd2, 32'h0F0F0000);
    set_req(2, 1'b0, 2'b00, 32'h0, 32'h0);
    set_req(3, 1'b1, 2'b10, 32'h000000FF, 32'h0000000F);
    for (int k = 0; k < 3; k++) begin
      chk_rdy("bp_hold", 4'b0000);
      tick();
      chk_rsp("bp_hold", 1'b1, 2'd2, 32'h0F0F0000);
    end
    rsp_ready = 1'b1;
    chk_rdy("bp_release", 4'b1000);
    tick();
    chk_rsp("bp_no_bubble", 1'b1, 2'd3, 32'h000000F0);

    // reset mid-operation with all requesters pending
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 2'(i), 32'hF0F0F0F0, 32'hFF00FF00);
    reset = 1'b1;
    chk_rdy("mid_reset_comb", 4'b0000);
    tick();
    chk_rsp("mid_reset", 1'b0, 2'd0, 32'h0);
    chk_rdy("mid_reset", 4'b0000);
    reset = 1'b0;

    // full contention from reset: 0,1,2,3,0,... one per cycle
    full_res[0] = 32'hF000F000;
    full_res[1] = 32'hFFF0FFF0;
    full_res[2] = 32'h0FF00FF0;
    full_res[3] = 32'h000F000F;
    for (int k = 0; k < 8; k++) begin
      full_rdy = 4'b0001 << (k % 4);
      chk_rdy("full_grant", full_rdy);
      tick();
      chk_rsp("full_rsp", 1'b1, 2'(k % 4), full_res[k % 4]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
